// File: rtl/usb_bit_pkg.sv
// Package usb_bit_pkg
//   Shared types and defaults for the USB receive-path bit unstuffer and
//   deserialiser.
//   unstuff_state_t   : S_RUN normal unstuffing, S_ERR waiting for sop/eop
//                       after a stuff violation
//   USB_STUFF_RUN_LEN : consecutive 1s after which the line inserts a 0
//   USB_OUT_W         : default output word width
package usb_bit_pkg;

    typedef enum logic {
        S_RUN = 1'b0,
        S_ERR = 1'b1
    } unstuff_state_t;

    localparam int USB_STUFF_RUN_LEN = 6;
    localparam int USB_OUT_W         = 8;

endpackage

// File: rtl/usb_stuff_run_counter.sv
// Module usb_stuff_run_counter
//   Tracks the run of consecutive 1s on the decoded line and classifies the
//   current bit against it.
//   clk, RST   : clock, synchronous active-high reset
//   in_bit     : decoded line bit
//   in_valid   : bit qualifier (already gated by the caller's FSM)
//   restart    : treat the run as empty for this bit (start of packet)
//   flush      : clear the run after this bit (end of packet)
//   cnt        : registered run count, saturates at RUN_LEN
//   drop       : current bit is the stuffed 0
//   viol       : current bit is a 1 where a stuffed 0 was due
module usb_stuff_run_counter
    import usb_bit_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN_LEN,
    localparam int CW = $clog2(RUN_LEN + 1)
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          in_bit,
    input  logic          in_valid,
    input  logic          restart,
    input  logic          flush,
    output logic [CW-1:0] cnt,
    output logic          drop,
    output logic          viol
);

    localparam logic [CW-1:0] RL = CW'(RUN_LEN);

    logic [CW-1:0] cur;
    logic [CW-1:0] cnt_nxt;
    logic          at_run;

    always_comb begin
        cur     = restart ? '0 : cnt;
        at_run  = (cur == RL);
        drop    = in_valid && at_run && !in_bit;
        viol    = in_valid && at_run && in_bit;
        cnt_nxt = cur;
        if (in_valid) begin
            if (!in_bit)
                cnt_nxt = '0;
            else if (!at_run)
                cnt_nxt = cur + 1'b1;
            // a 1 at a full run keeps the count saturated so the next 0
            // is still treated as the stuffed bit
        end
        if (flush)
            cnt_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (RST)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end

endmodule

// File: rtl/usb_bit_unstuffer_deser.sv
// Module usb_bit_unstuffer_deser
//   Removes USB stuffed bits after NRZI decode and packs the surviving bits
//   LSB-first into OUT_W-bit words, flushing a partial word at end of packet.
//   Optional stuff-error detection is built when USB_UNSTUFF_STUFF_ERR_EN is
//   defined; otherwise a violating 1 is kept as data and stuff_err stays 0.
//   clk, RST   : clock, synchronous active-high reset
//   in_bit     : decoded line bit, qualified by in_valid
//   in_sop     : start of packet, clears run/bit index/error state
//   in_eop     : end of packet, flushes pending bits then clears
//   out_data   : packed word, first received bit in [0]
//   out_valid  : one-cycle strobe for out_data/out_last/out_nbits
//   out_last   : word is the final one of the packet
//   out_nbits  : number of valid bits in out_data
//   stuff_err  : one-cycle pulse after a stuff violation
//   one_count  : current consecutive-1 run count
module usb_bit_unstuffer_deser
    import usb_bit_pkg::*;
#(
    parameter int RUN_LEN = USB_STUFF_RUN_LEN,
    parameter int OUT_W   = USB_OUT_W,
    localparam int CW = $clog2(RUN_LEN + 1),
    localparam int NW = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    output logic [NW-1:0]    out_nbits,
    output logic             stuff_err,
    output logic [CW-1:0]    one_count
);

    localparam int IW = $clog2(OUT_W);

`ifdef USB_UNSTUFF_STUFF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    unstuff_state_t   state, state_nxt;
    logic [OUT_W-1:0] shreg, shreg_nxt, cur_sh, sh_w;
    logic [IW-1:0]    bit_idx, bit_idx_nxt, cur_idx, idx_w;
    logic             restart, run_en, bit_v;
    logic             drop, viol, accept, err_hit, word_done;
    logic             emit, emit_last;
    logic [OUT_W-1:0] emit_data;
    logic [NW-1:0]    emit_nbits;

    usb_stuff_run_counter #(
        .RUN_LEN (RUN_LEN)
    ) u_run (
        .clk      (clk),
        .RST      (RST),
        .in_bit   (in_bit),
        .in_valid (bit_v),
        .restart  (restart),
        .flush    (in_eop),
        .cnt      (one_count),
        .drop     (drop),
        .viol     (viol)
    );

    always_ff @(posedge clk) begin
        if (RST)
            state <= S_RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        // sop alone starts a new packet with this cycle's bit; with eop the
        // bit belongs to the packet being flushed and sop only clears after
        restart = in_sop && !in_eop;
        run_en  = (state == S_RUN) || restart;
        bit_v   = in_valid && run_en;
        accept  = bit_v && !drop && !(ERR_EN && viol);
        err_hit = ERR_EN && viol;

        cur_sh  = restart ? '0 : shreg;
        cur_idx = restart ? '0 : bit_idx;

        sh_w = cur_sh;
        if (accept)
            sh_w[cur_idx] = in_bit;

        word_done = accept && (cur_idx == IW'(OUT_W - 1));
        if (word_done)
            idx_w = '0;
        else if (accept)
            idx_w = cur_idx + 1'b1;
        else
            idx_w = cur_idx;

        emit       = 1'b0;
        emit_last  = 1'b0;
        emit_data  = '0;
        emit_nbits = '0;
        if (word_done) begin
            emit       = 1'b1;
            emit_last  = in_eop;
            emit_data  = sh_w;
            emit_nbits = NW'(OUT_W);
        end else if (in_eop && (state == S_RUN) && !err_hit) begin
            // partial flush; bits above idx_w are already 0 in sh_w, and an
            // empty packet yields a zero-length terminator
            emit       = 1'b1;
            emit_last  = 1'b1;
            emit_data  = sh_w;
            emit_nbits = NW'(idx_w);
        end

        shreg_nxt   = (in_eop || word_done) ? '0 : sh_w;
        bit_idx_nxt = in_eop ? '0 : idx_w;

        state_nxt = state;
        if (in_eop || in_sop)
            state_nxt = S_RUN;
        else if (err_hit)
            state_nxt = S_ERR;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            shreg     <= '0;
            bit_idx   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_nbits <= '0;
            stuff_err <= 1'b0;
        end else begin
            shreg     <= shreg_nxt;
            bit_idx   <= bit_idx_nxt;
            out_valid <= emit;
            out_last  <= emit_last;
            out_data  <= emit_data;
            out_nbits <= emit_nbits;
            stuff_err <= err_hit;
        end
    end

endmodule

// File: tb/tb_usb_bit_unstuffer_deser.sv
// Bench for usb_bit_unstuffer_deser. Two instances share one stimulus
// stream: RUN_LEN=6/OUT_W=8 and RUN_LEN=3/OUT_W=4. A behavioural model
// predicts every emitted word and error pulse into per-instance queues;
// monitors pop and compare on the falling edge.
module tb_usb_bit_unstuffer_deser;

`ifdef USB_UNSTUFF_STUFF_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] nbits;
        logic       last;
        logic       vld;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic RST = 1'b1;
    logic in_bit = 1'b0, in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;

    logic [7:0] a_data;  logic a_valid, a_last, a_err;  logic [3:0] a_nbits; logic [2:0] a_oc;
    logic [3:0] b_data;  logic b_valid, b_last, b_err;  logic [2:0] b_nbits; logic [1:0] b_oc;

    int   n_chk = 0, n_pass = 0;
    bit   mon_en = 1'b0;
    exp_t q0[$], q1[$];

    int         m_cnt[2], m_idx[2];
    logic [7:0] m_sh[2];
    bit         m_err[2];

    always #5 clk = ~clk;

    usb_bit_unstuffer_deser #(.RUN_LEN(6), .OUT_W(8)) dut_a (
        .clk(clk), .RST(RST), .in_bit(in_bit), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .out_data(a_data), .out_valid(a_valid),
        .out_last(a_last), .out_nbits(a_nbits), .stuff_err(a_err), .one_count(a_oc));

    usb_bit_unstuffer_deser #(.RUN_LEN(3), .OUT_W(4)) dut_b (
        .clk(clk), .RST(RST), .in_bit(in_bit), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop), .out_data(b_data), .out_valid(b_valid),
        .out_last(b_last), .out_nbits(b_nbits), .stuff_err(b_err), .one_count(b_oc));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic model_clear(input int i);
        m_cnt[i] = 0; m_idx[i] = 0; m_sh[i] = '0; m_err[i] = 1'b0;
    endtask

    task automatic model_step(input int i, input bit sop, input bit eop, input bit v,
                              input bit b, output bit has, output exp_t e);
        int  rl, ow;
        bit  keep, done;
        rl = (i == 0) ? 6 : 3;
        ow = (i == 0) ? 8 : 4;
        has = 1'b0; e = '0; done = 1'b0;
        if (sop && !eop) model_clear(i);
        if (v && !m_err[i]) begin
            keep = 1'b1;
            if (m_cnt[i] == rl) begin
                if (!b) begin
                    keep = 1'b0; m_cnt[i] = 0;
                end else if (ERR_EN) begin
                    keep = 1'b0; m_err[i] = 1'b1; has = 1'b1; e.err = 1'b1;
                end
            end else begin
                m_cnt[i] = b ? m_cnt[i] + 1 : 0;
            end
            if (keep) begin
                m_sh[i][m_idx[i]] = b;
                m_idx[i]++;
                if (m_idx[i] == ow) begin
                    has = 1'b1; e.vld = 1'b1; e.data = m_sh[i];
                    e.nbits = 4'(ow); e.last = eop; done = 1'b1;
                    m_sh[i] = '0; m_idx[i] = 0;
                end
            end
        end
        if (eop) begin
            if (!done && !m_err[i]) begin
                has = 1'b1; e.vld = 1'b1; e.last = 1'b1;
                e.data = m_sh[i]; e.nbits = 4'(m_idx[i]);
            end
            model_clear(i);
        end
    endtask

    task automatic cyc(input bit sop, input bit eop, input bit v, input bit b);
        bit   h0, h1;
        exp_t e0, e1;
        in_sop = sop; in_eop = eop; in_valid = v; in_bit = b;
        model_step(0, sop, eop, v, b, h0, e0);
        model_step(1, sop, eop, v, b, h1, e1);
        @(posedge clk);
        if (h0) q0.push_back(e0);
        if (h1) q1.push_back(e1);
        #1;
        chk("a_one_count", 32'(a_oc), 32'(m_cnt[0]));
        chk("b_one_count", 32'(b_oc), 32'(m_cnt[1]));
        in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // bits sent LSB-first; sop on the first bit, optional eop on the last
    task automatic send_seq(input logic [31:0] bits, input int n, input bit eop_last);
        for (int k = 0; k < n; k++)
            cyc(k == 0, eop_last && (k == n - 1), 1'b1, bits[k]);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1; in_sop = 0; in_eop = 0; in_valid = 0; in_bit = 0;
        model_clear(0); model_clear(1);
        repeat (n) @(posedge clk);
        #1;
        chk("rst_a_outs", {a_data, a_valid, a_last, a_nbits, a_err, a_oc}, 32'h0);
        chk("rst_b_outs", {b_data, b_valid, b_last, b_nbits, b_err, b_oc}, 32'h0);
        RST = 1'b0;
    endtask

    task automatic sb_cmp(input string who, input bit have, input exp_t e,
                          input bit vld, input bit err, input bit last,
                          input logic [7:0] data, input logic [3:0] nbits);
        if (!have) begin
            chk({who, "_spurious"}, {30'b0, vld, err}, 32'h0);
        end else begin
            chk({who, "_valid"}, 32'(vld), 32'(e.vld));
            chk({who, "_stuff_err"}, 32'(err), 32'(e.err));
            if (e.vld) begin
                chk({who, "_data"}, 32'(data), 32'(e.data));
                chk({who, "_nbits"}, 32'(nbits), 32'(e.nbits));
                chk({who, "_last"}, 32'(last), 32'(e.last));
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (q0.size() > 0 || a_valid || a_err)) begin
            e = '0;
            if (q0.size() > 0) e = q0.pop_front();
            sb_cmp("a", q0.size() >= 0 && e != '0, e, a_valid, a_err, a_last, a_data, a_nbits);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && (q1.size() > 0 || b_valid || b_err)) begin
            e = '0;
            if (q1.size() > 0) e = q1.pop_front();
            sb_cmp("b", e != '0, e, b_valid, b_err, b_last, {4'b0, b_data}, {1'b0, b_nbits});
        end
    end

    initial begin
        logic [31:0] rb;
        int          len;
        do_reset(2);
        mon_en = 1'b1;

        send_seq(32'hA5, 8, 1'b0);            // plain byte, no eop
        idle(2);
        send_seq(32'h0BF, 9, 1'b0);           // 1x6,0,1,0: stuffed 0 dropped
        cyc(1'b0, 1'b1, 1'b0, 1'b0);          // eop with nothing pending on a
        idle(1);
        send_seq(32'h17F, 9, 1'b1);           // 1x7,0,1: violation
        idle(1);
        send_seq(32'hA5, 8, 1'b1);
        send_seq(32'h5, 3, 1'b0);             // 1,0,1 then separate eop
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);          // lone eop: terminator
        send_seq(32'hD, 4, 1'b0);             // partial word discarded by reset
        do_reset(1);
        send_seq(32'h3C, 8, 1'b1);
        send_seq(32'h17, 6, 1'b1);            // 1,1,1,0,1,0
        send_seq(32'h81, 8, 1'b1);            // eop completes a full word
        send_seq(32'h3, 2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);          // sop+eop: flush then clear
        send_seq(32'h7, 3, 1'b0);
        send_seq(32'h5A, 8, 1'b1);            // sop mid-packet restarts

        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 24);
            rb = 32'h0;
            for (int k = 0; k < len; k++) rb[k] = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 4) == 0) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                cyc(k == 0, k == len - 1, 1'b1, rb[k]);
            end
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("a_queue_drained", 32'(q0.size()), 32'h0);
        chk("b_queue_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
